// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
//   loader_state_t : loader FSM states
//   CNT_W          : width of the image word-count header field
package imem_loader_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
//   in_valid/in_data/in_ready : byte stream handshake
//   start                     : re-arm pulse (honoured in DONE/ERR only)
//   im_we/im_addr/im_wdata    : instruction-memory write port
//   cpu_rst/done/err          : processor reset and load status
// slave = loader side, master = byte source / memory / control side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              start;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data, start,
    input  in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
  );

  modport slave (
    input  in_valid, in_data, start,
    output in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler with running XOR checksum.
//   clk, rst      : clock, async active-high reset
//   clr_i         : synchronous clear of index, assembly register and XOR
//   byte_valid_i  : a data byte transfers this cycle
//   byte_i        : the data byte
//   word_valid_o  : this byte completes a word (combinational pulse)
//   word_o        : the completed word, valid with word_valid_o
//   xor_o         : XOR of all data bytes accepted since the last clear
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic [7:0]  xor_o
);

  logic [31:0] asm_q, asm_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  xor_q, xor_d;

  always_comb begin
    asm_d = asm_q;
    idx_d = idx_q;
    xor_d = xor_q;
    if (clr_i) begin
      asm_d = '0;
      idx_d = '0;
      xor_d = '0;
    end else if (byte_valid_i) begin
      // Shift right so the first byte of a word ends up in bits [7:0].
      asm_d = {byte_i, asm_q[31:8]};
      idx_d = idx_q + 2'd1;
      xor_d = xor_q ^ byte_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      idx_q <= '0;
      xor_q <= '0;
    end else begin
      asm_q <= asm_d;
      idx_q <= idx_d;
      xor_q <= xor_d;
    end
  end

  assign word_valid_o = byte_valid_i && !clr_i && (idx_q == 2'd3);
  assign word_o       = {byte_i, asm_q[31:8]};
  assign xor_o        = xor_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into instruction memory and holds
// the processor in reset until the image is written and its checksum matches.
// Stream: count_lo, count_hi, 4*count data bytes (LE words), XOR checksum.
//   clk, rst : clock, async active-high reset
//   bus      : imem_loader_if slave (stream, memory write port, status)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  // Number of words that fit between BASE_ADDR and the top of memory.
  localparam logic [31:0] ROOM = 32'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  widx_q, widx_d;
  logic [CNT_W-1:0]  hdr_count;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
  logic              cpu_rst_q, cpu_rst_d;
  logic              xfer, rearm;
  logic              word_valid;
  logic [31:0]       word;
  logic [7:0]        xor_sum;

  assign bus.in_ready = (state_q != DONE) && (state_q != ERR);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign rearm        = bus.start && ((state_q == DONE) || (state_q == ERR));
  assign hdr_count    = {bus.in_data, count_q[7:0]};

  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (rearm),
    .byte_valid_i (xfer && (state_q == DATA)),
    .byte_i       (bus.in_data),
    .word_valid_o (word_valid),
    .word_o       (word),
    .xor_o        (xor_sum)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    unique case (state_q)
      HDR_LO: if (xfer) begin
        count_d = {count_q[15:8], bus.in_data};
        state_d = HDR_HI;
      end
      HDR_HI: if (xfer) begin
        count_d = hdr_count;
        if (32'(hdr_count) > ROOM)  state_d = ERR;
        else if (hdr_count == '0)   state_d = CSUM;
        else                        state_d = DATA;
      end
      DATA: if (word_valid) begin
        widx_d = widx_q + 16'd1;
        if (widx_d == count_q) state_d = CSUM;
      end
      CSUM: if (xfer) begin
        state_d = (bus.in_data == xor_sum) ? DONE : ERR;
      end
      DONE, ERR: if (rearm) begin
        state_d = HDR_LO;
        count_d = '0;
        widx_d  = '0;
      end
      default: state_d = HDR_LO;
    endcase
    // Low only while DONE persists, so it falls one cycle after entering DONE
    // and rises together with the return to HDR_LO on a re-arm.
    cpu_rst_d = (state_q != DONE) || (state_d != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HDR_LO;
      count_q    <= '0;
      widx_q     <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= ADDR_W'(BASE_ADDR);
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      widx_q    <= widx_d;
      im_we_q   <= word_valid;
      cpu_rst_q <= cpu_rst_d;
      if (word_valid) begin
        im_addr_q  <= ADDR_W'(32'(BASE_ADDR) + 32'(widx_q));
        im_wdata_q <= word;
      end
    end
  end

  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign bus.cpu_rst  = cpu_rst_q;
  assign bus.done     = (state_q == DONE);
  assign bus.err      = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=8, BASE_ADDR=0).
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  logic [7:0]  xacc;
  bit          gaps;

  // Write log, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      wa.push_back(bus.im_addr);
      wd.push_back(bus.im_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  function automatic logic [31:0] pword(input int k);
    return {pat(4*k+3), pat(4*k+2), pat(4*k+1), pat(4*k)};
  endfunction

  // Present one byte from a negedge; returns at the negedge after it transferred.
  task automatic send(input logic [7:0] b);
    int n = 0;
    if (gaps) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(1, 0) == 0) break;
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    xacc = xacc ^ b;
    send(b);
  endtask

  task automatic header(input int n);
    logic [15:0] c;
    c = 16'(n);
    send(c[7:0]);
    send(c[15:8]);
  endtask

  task automatic load_pat(input int n);
    header(n);
    for (int i = 0; i < 4*n; i++) send_data(pat(i));
    send(xacc);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    xacc = 8'h00;
  endtask

  task automatic rearm();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  logic [7:0] img1 [8];
  logic [7:0] img2 [4];

  initial begin
    img1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    img2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.start    = 1'b0;
    gaps = 1'b0;
    xacc = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_im_we",    32'(bus.im_we),    32'd0);
    chk("rst_im_addr",  32'(bus.im_addr),  32'd0);
    chk("rst_im_wdata", bus.im_wdata,      32'd0);
    chk("rst_cpu_rst",  32'(bus.cpu_rst),  32'd1);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_err",      32'(bus.err),      32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Two-word image, good checksum 13^93^10 = 0x90
    clear_log();
    header(2);
    foreach (img1[i]) send_data(img1[i]);
    chk("t1_xacc_hand", 32'(xacc), 32'h90);
    send(8'h90);
    chk("t1_done",        32'(bus.done),    32'd1);
    chk("t1_cpu_rst_hold",32'(bus.cpu_rst), 32'd1);
    @(negedge clk);
    chk("t1_cpu_rst_low", 32'(bus.cpu_rst), 32'd0);
    chk("t1_in_ready",    32'(bus.in_ready),32'd0);
    chk("t1_nwrites",     32'(wa.size()),   32'd2);
    chk("t1_addr0", 32'(wa[0]), 32'd0);
    chk("t1_data0", wd[0],      32'h0000_0013);
    chk("t1_addr1", 32'(wa[1]), 32'd1);
    chk("t1_data1", wd[1],      32'h0010_0093);

    // Same image, bad checksum
    rearm();
    chk("t2_rearm_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("t2_rearm_done",    32'(bus.done),    32'd0);
    chk("t2_rearm_ready",   32'(bus.in_ready),32'd1);
    clear_log();
    header(2);
    foreach (img1[i]) send_data(img1[i]);
    send(8'h81);
    @(negedge clk);
    chk("t2_err",      32'(bus.err),      32'd1);
    chk("t2_done",     32'(bus.done),     32'd0);
    chk("t2_cpu_rst",  32'(bus.cpu_rst),  32'd1);
    chk("t2_in_ready", 32'(bus.in_ready), 32'd0);

    // Empty image
    rearm();
    chk("t3_err_cleared", 32'(bus.err), 32'd0);
    clear_log();
    header(0);
    send(8'h00);
    @(negedge clk);
    chk("t3_done",    32'(bus.done),  32'd1);
    chk("t3_nwrites", 32'(wa.size()), 32'd0);

    // Count one past capacity
    rearm();
    clear_log();
    header(257);
    @(negedge clk);
    chk("t4_err",      32'(bus.err),      32'd1);
    chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t4_nwrites",  32'(wa.size()),    32'd0);

    // Count exactly at capacity
    rearm();
    clear_log();
    load_pat(256);
    chk("t5_done",     32'(bus.done),    32'd1);
    chk("t5_nwrites",  32'(wa.size()),   32'd256);
    chk("t5_addr0",    32'(wa[0]),       32'd0);
    chk("t5_addr_last",32'(wa[255]),     32'hFF);
    chk("t5_data_last",wd[255],          pword(255));

    // Four words, gapless then with random in_valid gaps
    for (int pass = 0; pass < 2; pass++) begin
      rearm();
      clear_log();
      gaps = (pass == 1);
      load_pat(4);
      gaps = 1'b0;
      chk("t6_done",    32'(bus.done),  32'd1);
      chk("t6_nwrites", 32'(wa.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
        chk("t6_addr", 32'(wa[k]), 32'(k));
        chk("t6_data", wd[k],      pword(k));
      end
    end

    // Reset in the middle of the second word, then a clean reload
    rearm();
    clear_log();
    header(2);
    for (int i = 0; i < 6; i++) send_data(pat(i));
    chk("t7_pre_rst_nwrites", 32'(wa.size()), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_ready",   32'(bus.in_ready), 32'd1);
    chk("t7_rst_cpu_rst", 32'(bus.cpu_rst),  32'd1);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    header(1);
    foreach (img2[i]) send_data(img2[i]);
    send(8'h00);
    @(negedge clk);
    chk("t7_done",    32'(bus.done),  32'd1);
    chk("t7_nwrites", 32'(wa.size()), 32'd1);
    chk("t7_addr0",   32'(wa[0]),     32'd0);
    chk("t7_data0",   wd[0],          32'hDDCC_BBAA);
    chk("t7_im_we",   32'(bus.im_we), 32'd0);
    rearm();
    chk("t7_rearm_ready",   32'(bus.in_ready), 32'd1);
    chk("t7_rearm_cpu_rst", 32'(bus.cpu_rst),  32'd1);
    chk("t7_rearm_done",    32'(bus.done),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
